// File: rtl/uart_word_loader_pkg.sv
// Shared types and constants for the UART program-load front end.
package uart_word_loader_pkg;

    localparam int unsigned LOADER_ADDR_WIDTH = 25;
    localparam int unsigned WORD_WIDTH        = 16;
    localparam int unsigned BYTE_WIDTH        = 8;

    // Write state machine: wait for data, strobe the controller, wait for completion.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } state_t;

endpackage

// File: rtl/loader_fifo.sv
// Synchronous word FIFO for the UART loader. A push into a full FIFO is accepted
// only when a pop happens on the same edge; clear empties it and wins over both.
module loader_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW:0]    wr_ptr_q;
    logic [PtrW:0]    rd_ptr_q;
    logic             do_pop;
    logic             do_push;

    // Extra pointer bit distinguishes full from empty when the indices match.
    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                  (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rdata   = mem[rd_ptr_q[PtrW-1:0]];
    end

    // Pointer update; clear takes priority over any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (PtrW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
        end
    end

    // Storage needs no reset; contents are only read when the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr_q[PtrW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_word_loader.sv
// UART-to-SDRAM program loader: pairs bytes into big-endian words, buffers them and
// writes them to consecutive word addresses from 0. Optional running checksum is
// enabled by defining UART_LOADER_CHECKSUM_EN.
module uart_word_loader
    import uart_word_loader_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = LOADER_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic                  uart_byte_ready,
    input  logic [BYTE_WIDTH-1:0] uart_byte,
    input  logic                  dram_mem_ready,
    output logic                  dram_write_en,
    output logic                  dram_refresh_data,
    output logic [ADDR_WIDTH-1:0] dram_addr,
    output logic [WORD_WIDTH-1:0] dram_data_in,
    output logic [ADDR_WIDTH-1:0] word_count,
    output logic                  busy,
    output logic                  overflow,
    output logic [WORD_WIDTH-1:0] checksum
);

    logic                  load_en_q;
    logic                  phase_q;
    logic [BYTE_WIDTH-1:0] hi_byte_q;
    logic                  overflow_q;
    state_t                state_q;
    logic                  wait_first_q;
    logic                  stale_q;
    logic                  write_en_q;
    logic                  refresh_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_WIDTH-1:0] data_q;
    logic [ADDR_WIDTH-1:0] word_count_q;

    logic                  load_start;
    logic                  byte_accept;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  write_done;
    logic [WORD_WIDTH-1:0] fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Load start, byte pairing and FIFO handshake decode.
    always_comb begin
        load_start  = load_en && !load_en_q;
        byte_accept = uart_byte_ready && load_en;
        push        = byte_accept && phase_q && !load_start;
        // No pop on a load start: the FIFO is being cleared on that edge.
        pop         = (state_q == StIdle) && !fifo_empty && dram_mem_ready && !load_start;
        drop        = push && fifo_full && !pop;
        // A write that began before the current load start does not count.
        write_done  = (state_q == StWait) && !wait_first_q && dram_mem_ready &&
                      !stale_q && !load_start;
    end

    loader_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (load_start),
        .push  (push),
        .pop   (pop),
        .wdata ({hi_byte_q, uart_byte}),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Load-switch edge history, byte phase and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_en_q  <= 1'b1;
            phase_q    <= 1'b0;
            hi_byte_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            load_en_q <= load_en;
            if (load_start) begin
                phase_q    <= byte_accept;
                overflow_q <= 1'b0;
                if (byte_accept) hi_byte_q <= uart_byte;
            end else begin
                if (byte_accept) begin
                    phase_q <= !phase_q;
                    if (!phase_q) hi_byte_q <= uart_byte;
                end
                if (drop) overflow_q <= 1'b1;
            end
        end
    end

    // Write state machine with registered SDRAM-side outputs and word counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            wait_first_q <= 1'b0;
            stale_q      <= 1'b0;
            write_en_q   <= 1'b0;
            refresh_q    <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            word_count_q <= '0;
        end else begin
            if (load_start) begin
                word_count_q <= '0;
                stale_q      <= (state_q != StIdle);
            end
            case (state_q)
                StIdle: begin
                    if (pop) begin
                        state_q    <= StIssue;
                        refresh_q  <= 1'b1;
                        write_en_q <= 1'b1;
                        data_q     <= fifo_head;
                        addr_q     <= word_count_q;
                    end
                end
                StIssue: begin
                    refresh_q    <= 1'b0;
                    wait_first_q <= 1'b1;
                    state_q      <= StWait;
                end
                StWait: begin
                    if (wait_first_q) begin
                        wait_first_q <= 1'b0;
                    end else if (dram_mem_ready) begin
                        state_q    <= StIdle;
                        write_en_q <= 1'b0;
                        stale_q    <= 1'b0;
                        if (write_done) word_count_q <= word_count_q + ADDR_WIDTH'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef UART_LOADER_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] checksum_q;

    // Running 16-bit sum of completed words, restarted at each load start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum_q <= '0;
        end else if (load_start) begin
            checksum_q <= '0;
        end else if (write_done) begin
            checksum_q <= checksum_q + data_q;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign dram_write_en     = write_en_q;
    assign dram_refresh_data = refresh_q;
    assign dram_addr         = addr_q;
    assign dram_data_in      = data_q;
    assign word_count        = word_count_q;
    assign overflow          = overflow_q;
    assign busy              = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_uart_word_loader.sv
// Self-checking bench for uart_word_loader: a word-level model (expected write
// queue, address counter, running sum) checked every cycle, plus literal checks.
module tb_uart_word_loader;

    localparam int DEPTH = 4;
    localparam int AW    = 25;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_en = 1'b0;
    logic          uart_byte_ready = 1'b0;
    logic [7:0]    uart_byte = 8'h00;
    logic          dram_mem_ready = 1'b0;
    logic          dram_write_en;
    logic          dram_refresh_data;
    logic [AW-1:0] dram_addr;
    logic [15:0]   dram_data_in;
    logic [AW-1:0] word_count;
    logic          busy;
    logic          overflow;
    logic [15:0]   checksum;

    uart_word_loader #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .load_en           (load_en),
        .uart_byte_ready   (uart_byte_ready),
        .uart_byte         (uart_byte),
        .dram_mem_ready    (dram_mem_ready),
        .dram_write_en     (dram_write_en),
        .dram_refresh_data (dram_refresh_data),
        .dram_addr         (dram_addr),
        .dram_data_in      (dram_data_in),
        .word_count        (word_count),
        .busy              (busy),
        .overflow          (overflow),
        .checksum          (checksum)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Model state: words still owed to SDRAM in order, next address, completed count.
    logic [15:0]   exp_q[$];
    int            exp_addr = 0;
    int            exp_done = 0;
    logic [15:0]   exp_sum  = 16'h0;
    logic          exp_ovf  = 1'b0;
    logic          m_phase  = 1'b0;
    logic [7:0]    m_hi     = 8'h00;
    int            strobe_cnt = 0;
    logic [15:0]   held_data = 16'h0;
    logic [AW-1:0] held_addr = '0;
    logic [15:0]   last_data = 16'h0;
    logic [AW-1:0] last_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst) begin
            check("overflow_track", 32'(overflow), 32'(exp_ovf));
            if (dram_refresh_data) begin
                strobe_cnt++;
                last_data = dram_data_in;
                last_addr = dram_addr;
                check("strobe_write_en", 32'(dram_write_en), 32'h1);
                check("strobe_expected", 32'(exp_q.size() != 0), 32'h1);
                if (exp_q.size() != 0) begin
                    check("strobe_addr", 32'(dram_addr), 32'(exp_addr[AW-1:0]));
                    check("strobe_data", 32'(dram_data_in), 32'(exp_q[0]));
                    exp_sum = exp_sum + exp_q[0];
                    held_data = exp_q[0];
                    held_addr = exp_addr[AW-1:0];
                    void'(exp_q.pop_front());
                    exp_addr++;
                    exp_done++;
                end
            end else if (dram_write_en) begin
                check("hold_addr", 32'(dram_addr), 32'(held_addr));
                check("hold_data", 32'(dram_data_in), 32'(held_data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_phase  = 1'b0;
        exp_addr = 0;
        exp_done = 0;
        exp_sum  = 16'h0;
        exp_ovf  = 1'b0;
    endtask

    // One-cycle byte pulse; model updated after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        uart_byte       = b;
        uart_byte_ready = 1'b1;
        tick();
        uart_byte_ready = 1'b0;
        if (load_en) begin
            if (!m_phase) begin
                m_hi    = b;
                m_phase = 1'b1;
            end else begin
                m_phase = 1'b0;
                if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
                else exp_q.push_back({m_hi, b});
            end
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[15:8]);
        tick();
        send_byte(w[7:0]);
        tick();
    endtask

    task automatic set_load(input logic v);
        logic prev;
        prev    = load_en;
        load_en = v;
        tick();
        if (v && !prev) model_clear();
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && !dram_write_en) begin
                done = 1'b1;
                break;
            end
        end
        check("idle_reached", 32'(done), 32'h1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int s0;
        // Reset state.
        #2 rst = 1'b0;
        #1;
        check("rst_write_en", 32'(dram_write_en), 32'h0);
        check("rst_refresh", 32'(dram_refresh_data), 32'h0);
        check("rst_addr", 32'(dram_addr), 32'h0);
        check("rst_data", 32'(dram_data_in), 32'h0);
        check("rst_word_count", 32'(word_count), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_checksum", 32'(checksum), 32'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Pulses with the load switch off are ignored.
        dram_mem_ready = 1'b1;
        s0 = strobe_cnt;
        send_byte(8'h55);
        tick();
        send_byte(8'h66);
        for (int i = 0; i < 8; i++) tick();
        check("ignored_no_strobe", 32'(strobe_cnt - s0), 32'h0);
        check("ignored_busy", 32'(busy), 32'h0);

        // Single word with latency check.
        set_load(1'b1);
        send_byte(8'h12);
        tick();
        send_byte(8'h34);
        @(negedge clk);
        check("strobe_not_early", 32'(dram_refresh_data), 32'h0);
        @(negedge clk);
        check("strobe_latency", 32'(dram_refresh_data), 32'h1);
        check("single_addr", 32'(dram_addr), 32'h0);
        check("single_data", 32'(dram_data_in), 32'h1234);
        tick();
        wait_idle();
        check("single_count", 32'(word_count), 32'h1);
        check("single_count_model", 32'(word_count), 32'(exp_done));

        // Checksum wrap: 0xFFFF + 0x0002.
        set_load(1'b0);
        set_load(1'b1);
        send_word(16'hFFFF);
        send_word(16'h0002);
        wait_idle();
        check("cks_count", 32'(word_count), 32'h2);
`ifdef UART_LOADER_CHECKSUM_EN
        check("cks_value", 32'(checksum), 32'h0001);
        check("cks_model", 32'(checksum), 32'(exp_sum));
`else
        check("cks_value", 32'(checksum), 32'h0000);
`endif

        // Overflow: controller stalled, five words into a four-deep FIFO.
        dram_mem_ready = 1'b0;
        set_load(1'b0);
        set_load(1'b1);
        s0 = strobe_cnt;
        for (int i = 0; i < 5; i++) begin
            send_word({8'hA0 + 8'(i), 8'h50 + 8'(i)});
            if (i == 3) check("ovf_before_drop", 32'(overflow), 32'h0);
        end
        check("ovf_set", 32'(overflow), 32'h1);
        check("ovf_busy", 32'(busy), 32'h1);
        check("ovf_no_strobe_stalled", 32'(strobe_cnt - s0), 32'h0);
        dram_mem_ready = 1'b1;
        wait_idle();
        check("ovf_writes", 32'(strobe_cnt - s0), 32'h4);
        check("ovf_last_addr", 32'(last_addr), 32'h3);
        check("ovf_last_data", 32'(last_data), 32'hA353);
        check("ovf_count", 32'(word_count), 32'h4);
        check("ovf_sticky", 32'(overflow), 32'h1);

        // Lone first byte discarded by a new load start.
        set_load(1'b0);
        set_load(1'b1);
        send_byte(8'hAB);
        tick();
        set_load(1'b0);
        set_load(1'b1);
        s0 = strobe_cnt;
        send_word(16'h0102);
        wait_idle();
        check("partial_writes", 32'(strobe_cnt - s0), 32'h1);
        check("partial_data", 32'(last_data), 32'h0102);
        check("partial_addr", 32'(last_addr), 32'h0);
        check("partial_count", 32'(word_count), 32'h1);
        check("partial_overflow", 32'(overflow), 32'h0);

        // Reset during the wait phase of the second write of a load.
        set_load(1'b0);
        set_load(1'b1);
        send_word(16'h7788);
        wait_idle();
        send_byte(8'h99);
        tick();
        send_byte(8'h66);
        @(negedge clk);
        @(negedge clk);
        check("rmw_strobe", 32'(dram_refresh_data), 32'h1);
        #1 dram_mem_ready = 1'b0;
        @(posedge clk);
        #2;
        check("rmw_in_wait", 32'(dram_write_en), 32'h1);
        check("rmw_count_before", 32'(word_count), 32'h1);
        rst = 1'b0;
        #1;
        model_clear();
        check("rmw_write_en", 32'(dram_write_en), 32'h0);
        check("rmw_refresh", 32'(dram_refresh_data), 32'h0);
        check("rmw_addr", 32'(dram_addr), 32'h0);
        check("rmw_data", 32'(dram_data_in), 32'h0);
        check("rmw_count", 32'(word_count), 32'h0);
        check("rmw_busy", 32'(busy), 32'h0);
        check("rmw_checksum", 32'(checksum), 32'h0);
        tick();
        tick();
        rst = 1'b1;
        dram_mem_ready = 1'b1;
        tick();
        set_load(1'b0);
        set_load(1'b1);
        send_word(16'h5AA5);
        wait_idle();
        check("post_rst_addr", 32'(last_addr), 32'h0);
        check("post_rst_data", 32'(last_data), 32'h5AA5);
        check("post_rst_count", 32'(word_count), 32'h1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
